// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage ARM core.
//   REG_W    : register index width
//   STALL_W  : width of the stall performance counter
//   FLUSH_W  : width of the flush performance counter
//   state_e  : memory-wait tracking state (RUN, WAIT, ERR)
package arm_pipe_pkg;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned STALL_W = 32;
  localparam int unsigned FLUSH_W = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID-stage sources and the
// EXE/MEM-stage destinations.
//   id_src1/2, id_use_src1/2 : sources of the ID instruction and whether read
//   exe_wb_en, exe_dest      : EXE writer and its destination
//   exe_mem_read             : EXE instruction is a load
//   mem_wb_en, mem_dest      : MEM writer and its destination
//   hazard                   : ID instruction must be held one cycle
module hazard_detect #(
  parameter int unsigned REG_W  = arm_pipe_pkg::REG_W,
  parameter bit          FWD_EN = 1'b0
) (
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);

  logic exe_match;
  logic mem_match;

  // Source-vs-destination match, only for sources the instruction actually reads
  always_comb begin
    exe_match = (id_use_src1 && (id_src1 == exe_dest)) ||
                (id_use_src2 && (id_src2 == exe_dest));
    mem_match = (id_use_src1 && (id_src1 == mem_dest)) ||
                (id_use_src2 && (id_src2 == mem_dest));
  end

  // With forwarding only a load result is too late; without it any pending writer is
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN) begin
      hazard = exe_mem_read && exe_wb_en && exe_match;
    end else begin
      hazard = (exe_wb_en && exe_match) || (mem_wb_en && mem_match);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control unit: freeze/bubble/flush generation, memory-wait timeout
// tracking and stall/flush performance counters.
//   clk, rst (async, active-low)
//   id_*, exe_*, mem_wb_en, mem_dest : register usage in ID/EXE/MEM
//   exe_branch_taken                 : branch resolved taken in EXE
//   mem_req, mem_ready               : MEM-stage memory handshake
//   freeze_front, bubble_id          : hold PC + IF/ID, zero ID/EXE controls (comb)
//   flush_front                      : clear IF/ID and ID/EXE (comb)
//   freeze_all                       : hold every pipeline register and PC (comb)
//   mem_err                          : sticky memory timeout (registered)
//   stall_cnt, flush_cnt             : saturating performance counters (registered)
module hazard_ctrl #(
  parameter int unsigned REG_W   = arm_pipe_pkg::REG_W,
  parameter bit          FWD_EN  = 1'b0,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_id,
  output logic             flush_front,
  output logic             freeze_all,
  output logic             mem_err,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  import arm_pipe_pkg::state_e;
  import arm_pipe_pkg::RUN;
  import arm_pipe_pkg::WAIT;
  import arm_pipe_pkg::ERR;

  // Wait counter only needs to reach TIMEOUT-1
  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              mem_err_d;
  logic              hazard;
  logic              mem_stall;

  hazard_detect #(
    .REG_W  (REG_W),
    .FWD_EN (FWD_EN)
  ) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_read (exe_mem_read),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  assign mem_stall = mem_req && !mem_ready;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err    <= mem_err_d;
    end
  end

  // Next state: count consecutive unready cycles, ERR is terminal until reset
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d   = ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERR: begin
        mem_err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Priority: global freeze > branch flush > hazard stall; all forced low in reset
  always_comb begin
    freeze_all   = 1'b0;
    flush_front  = 1'b0;
    freeze_front = 1'b0;
    bubble_id    = 1'b0;
    if (!rst) begin
      freeze_all = 1'b0;
    end else if (mem_stall || (state_q == ERR)) begin
      freeze_all = 1'b1;
    end else if (exe_branch_taken) begin
      flush_front = 1'b1;
    end else if (hazard) begin
      freeze_front = 1'b1;
      bubble_id    = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze_front || freeze_all) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_front && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule
